sram_fifo_ctrl: RTL and testbench

Sequential access controller that sits directly upstream of the 128×8 `SRAM` register array and turns it into a first-in/first-out buffer with valid/ready handshakes on both sides. The producer pushes bytes; the block drives the SRAM write port (`writeReg`, `writeData`, `regWrite`) with a safe setup/strobe/hold sequence, because the array writes whenever `regWrite` is high. It also reads through the combinational read port (`readReg` → `readData`) into a registered output stage for the consumer.

---
 rtl/sram_fifo_ctrl.sv | 64 ++++++
 tb/tb_sram_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over a 128x8 SRAM with a setup/strobe/hold write sequence and a registered output stage
module sram_fifo_ctrl #(
  parameter int DEPTH = 128,
  parameter int PTR_W = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] level,
  output logic [7:0] sram_write_reg,
  output logic [7:0] sram_write_data,
  output logic       sram_reg_write,
  output logic [7:0] sram_read_reg,
  input  logic [7:0] sram_read_data
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state, stateNext;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0] sramCount;
  logic [7:0] wdata;
  logic commit, load;
  always_comb begin
    stateNext = state;
    in_ready = (state == IDLE) && (sramCount != (PTR_W+1)'(DEPTH));
    commit = state == HOLD;
    load = (sramCount != '0) && (!out_valid || out_ready);
    stateNext = state == IDLE ? (in_valid && in_ready ? SETUP : IDLE) :
                state == SETUP ? STROBE : state == STROBE ? HOLD : IDLE;
  end
  assign level = 8'(sramCount) + {7'd0, out_valid};
  assign sram_write_reg = 8'(wrPtr);
  assign sram_read_reg = 8'(rdPtr);
  assign sram_write_data = wdata;
  // Strobe is its own flop so it is glitch-free and high exactly during STROBE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wrPtr <= '0;
      rdPtr <= '0;
      sramCount <= '0;
      wdata <= '0;
      sram_reg_write <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= stateNext;
      sram_reg_write <= state == SETUP;
      if (state == IDLE && in_valid && in_ready) wdata <= in_data;
      if (commit) wrPtr <= wrPtr + PTR_W'(1);
      if (load) begin
        rdPtr <= rdPtr + PTR_W'(1);
        out_data <= sram_read_data;
      end
      sramCount <= sramCount + (PTR_W+1)'(commit) - (PTR_W+1)'(load);
      if (load) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: scoreboard bench for sram_fifo_ctrl with a behavioural 128x8 SRAM
module tb_sram_fifo_ctrl;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, sram_reg_write;
  logic [7:0] out_data, level, sram_write_reg, sram_write_data, sram_read_reg, sram_read_data;
  logic [7:0] mem [128];
  int cmpCount = 0, errCount = 0;
  logic [7:0] q[$], wq[$];
  logic [6:0] expAddr = 0;
  logic stall = 0;
  logic [7:0] stallData;

  sram_fifo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
    .sram_write_reg(sram_write_reg), .sram_write_data(sram_write_data), .sram_reg_write(sram_reg_write),
    .sram_read_reg(sram_read_reg), .sram_read_data(sram_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (sram_reg_write) mem[sram_write_reg[6:0]] <= sram_write_data;
  assign sram_read_data = mem[sram_read_reg[6:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic emptyPop(input string name);
    cmpCount++;
    errCount++;
    $display("FAIL %s: DUT produced a transfer with nothing expected", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input int budget, output bit ok);
    in_valid = 1;
    in_data = b;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      ok = in_ready;
      tick;
    end
    in_valid = 0;
  endtask

  task automatic doReset;
    reset_n = 0;
    #1;
    reset_n = 1;
    tick;
  endtask

  always @(negedge reset_n) begin
    q.delete();
    wq.delete();
    expAddr = 0;
    stall = 0;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, stallData);
      end
      stall = out_valid && !out_ready;
      stallData = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) emptyPop("pop_empty");
        else check("out_data", out_data, q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        wq.push_back(in_data);
      end
      if (sram_reg_write) begin
        if (wq.size() == 0) emptyPop("strobe_empty");
        else begin
          check("wr_data", sram_write_data, wq.pop_front());
          check("wr_addr", sram_write_reg, {1'b0, expAddr});
          expAddr++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    int acc, n;
    repeat (2) tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_strobe", sram_reg_write, 0);
    check("rst_out_data", out_data, 0);
    reset_n = 1;
    tick;
    out_ready = 1;
    in_valid = 1;
    in_data = 8'hA5;
    check("idle_ready", in_ready, 1);
    tick;
    in_valid = 0;
    check("c1_strobe", sram_reg_write, 0);
    check("c1_wdata", sram_write_data, 8'hA5);
    check("c1_wreg", sram_write_reg, 0);
    check("c1_ready", in_ready, 0);
    tick;
    check("c2_strobe", sram_reg_write, 1);
    tick;
    check("c3_strobe", sram_reg_write, 0);
    check("c3_level", level, 0);
    tick;
    check("c4_valid", out_valid, 0);
    check("c4_level", level, 1);
    tick;
    check("c5_valid", out_valid, 1);
    check("c5_data", out_data, 8'hA5);
    tick;
    check("c6_level", level, 0);
    out_ready = 0;
    acc = 0;
    for (int i = 0; i <= 130; i++) begin
      push(8'(i), 8, ok);
      acc += int'(ok);
    end
    repeat (4) tick;
    check("fill_accepted", acc, 129);
    check("fill_level", level, 129);
    check("fill_ready", in_ready, 0);
    check("fill_head", out_data, 0);
    check("fill_valid", out_valid, 1);
    out_ready = 1;
    n = 0;
    for (int i = 0; i < 129; i++) begin
      n += int'(out_valid);
      tick;
    end
    check("drain_count", n, 129);
    check("drain_valid", out_valid, 0);
    check("drain_level", level, 0);
    check("drain_rptr", sram_read_reg, 2);
    check("drain_wptr", sram_write_reg, 2);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      push(8'hE0 + 8'(i), 8, ok);
      acc += int'(ok);
    end
    repeat (8) tick;
    check("post_accepted", acc, 10);
    check("post_level", level, 0);
    check("post_wptr", sram_write_reg, 12);
    out_ready = 0;
    doReset;
    push(8'h11, 8, ok);
    repeat (3) tick;
    push(8'h22, 8, ok);
    repeat (3) tick;
    push(8'h33, 8, ok);
    tick;
    tick;
    check("sim_pre_level", level, 2);
    out_ready = 1;
    tick;
    out_ready = 0;
    check("sim_level", level, 2);
    check("sim_rptr", sram_read_reg, 2);
    check("sim_wptr", sram_write_reg, 3);
    check("sim_head", out_data, 8'h22);
    fork
      begin
        bit okA;
        for (int i = 0; i < 12; i++) push(8'h40 + 8'(i), 8, okA);
      end
      begin
        for (int k = 0; k < 150; k++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick;
        end
        out_ready = 1;
      end
    join
    repeat (10) tick;
    check("bp_level", level, 0);
    check("bp_sb_empty", q.size(), 0);
    out_ready = 0;
    doReset;
    for (int i = 1; i <= 3; i++) begin
      push(8'(i), 8, ok);
      repeat (3) tick;
    end
    check("pre_level", level, 3);
    push(8'h04, 8, ok);
    tick;
    check("mid_strobe", sram_reg_write, 1);
    reset_n = 0;
    #1;
    check("ar_strobe", sram_reg_write, 0);
    check("ar_level", level, 0);
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_wreg", sram_write_reg, 0);
    check("ar_rreg", sram_read_reg, 0);
    check("ar_wdata", sram_write_data, 0);
    #1;
    reset_n = 1;
    tick;
    out_ready = 1;
    push(8'h3C, 8, ok);
    for (int i = 0; i < 10 && !out_valid; i++) tick;
    check("rb_valid", out_valid, 1);
    check("rb_data", out_data, 8'h3C);
    tick;
    check("rb_rptr", sram_read_reg, 1);
    check("rb_level", level, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end
endmodule
